// File: rtl/pom_task_sender.sv
// Accelerator-side initiator of the new-task protocol: buffers one task-creation
// request, streams it to the gateway tagged with ACC_ID, and retries on reject acks.
module pom_task_sender #(
    parameter logic [4:0] ACC_ID      = 5'h00,
    parameter int         MAX_WORDS   = 16,
    parameter int         RETRY_DELAY = 64
) (
    input  logic        clk,
    input  logic        aresetn,
    input  logic        acc_task_tvalid,
    output logic        acc_task_tready,
    input  logic [63:0] acc_task_tdata,
    input  logic        acc_task_tlast,
    input  logic [4:0]  acc_task_tdest,
    output logic        out_tvalid,
    input  logic        out_tready,
    output logic [63:0] out_tdata,
    output logic        out_tlast,
    output logic [4:0]  out_tid,
    output logic [4:0]  out_tdest,
    input  logic        ack_tvalid,
    output logic        ack_tready,
    input  logic [7:0]  ack_tdata,
    output logic        result_valid,
    input  logic        result_ready,
    output logic [1:0]  result_code,
    output logic        overflow,
    output logic [15:0] retry_count
);
    localparam int IW = $clog2(MAX_WORDS);
    localparam int LW = IW + 1;
    localparam int BW = $clog2(RETRY_DELAY + 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LOAD     = 3'd1;
    localparam logic [2:0] S_SEND     = 3'd2;
    localparam logic [2:0] S_WAIT_ACK = 3'd3;
    localparam logic [2:0] S_BACKOFF  = 3'd4;
    localparam logic [2:0] S_REPORT   = 3'd5;

    logic [2:0]    state_q, state_d;
    logic [LW-1:0] len_q, len_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [BW-1:0] backoff_q, backoff_d;
    logic [4:0]    tdest_q, tdest_d;
    logic [1:0]    code_q, code_d;
    logic          overflow_q, overflow_d;
    logic [15:0]   retry_q, retry_d;

    logic [63:0]   buf_mem [MAX_WORDS];
    logic          wr_en;
    logic [IW-1:0] wr_addr;
    logic          acc_hs;
    logic          send_last;

    // tready is forced low while reset is asserted, even though IDLE would otherwise accept.
    assign acc_task_tready = aresetn && (state_q == S_IDLE || state_q == S_LOAD);
    assign acc_hs          = acc_task_tvalid && acc_task_tready;
    assign send_last       = (LW'(idx_q) == len_q - LW'(1));

    assign out_tvalid   = (state_q == S_SEND);
    assign out_tdata    = out_tvalid ? buf_mem[idx_q] : 64'd0;
    assign out_tlast    = out_tvalid && send_last;
    assign out_tid      = ACC_ID;
    assign out_tdest    = tdest_q;
    assign ack_tready   = (state_q == S_WAIT_ACK);
    assign result_valid = (state_q == S_REPORT);
    assign result_code  = code_q;
    assign overflow     = overflow_q;
    assign retry_count  = retry_q;

    always_comb begin
        // NOTE: every signal gets a default here so no path through the case infers a latch.
        state_d    = state_q;
        len_d      = len_q;
        idx_d      = idx_q;
        backoff_d  = backoff_q;
        tdest_d    = tdest_q;
        code_d     = code_q;
        overflow_d = overflow_q;
        retry_d    = retry_q;
        wr_en      = 1'b0;
        wr_addr    = '0;

        case (state_q)
            S_IDLE: if (acc_hs) begin
                wr_en   = 1'b1;
                tdest_d = acc_task_tdest;
                len_d   = LW'(1);
                idx_d   = '0;
                state_d = acc_task_tlast ? S_SEND : S_LOAD;
            end
            S_LOAD: if (acc_hs) begin
                if (len_q == LW'(MAX_WORDS)) begin
                    overflow_d = 1'b1;
                end else begin
                    wr_en   = 1'b1;
                    wr_addr = len_q[IW-1:0];
                    len_d   = len_q + LW'(1);
                end
                if (acc_task_tlast) state_d = S_SEND;
            end
            S_SEND: if (out_tready) begin
                if (send_last) begin
                    idx_d   = '0;
                    state_d = S_WAIT_ACK;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            S_WAIT_ACK: if (ack_tvalid) begin
                case (ack_tdata)
                    8'h01: begin code_d = 2'b01; state_d = S_REPORT; end
                    8'h02: begin code_d = 2'b10; state_d = S_REPORT; end
                    default: begin
                        if (retry_q != 16'hFFFF) retry_d = retry_q + 16'd1;
                        backoff_d = BW'(RETRY_DELAY);
                        state_d   = S_BACKOFF;
                    end
                endcase
            end
            S_BACKOFF: begin
                // Leaving when the counter hits zero gives exactly RETRY_DELAY idle cycles.
                backoff_d = backoff_q - BW'(1);
                if (backoff_q <= BW'(1)) begin
                    idx_d   = '0;
                    state_d = S_SEND;
                end
            end
            S_REPORT: if (result_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            idx_q      <= '0;
            backoff_q  <= '0;
            tdest_q    <= '0;
            code_q     <= '0;
            overflow_q <= 1'b0;
            retry_q    <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            backoff_q  <= backoff_d;
            tdest_q    <= tdest_d;
            code_q     <= code_d;
            overflow_q <= overflow_d;
            retry_q    <= retry_d;
        end
    end

    // NOTE: the buffer has no reset; len_q gates which entries are ever read, so stale data is harmless.
    always_ff @(posedge clk) begin
        if (wr_en) buf_mem[wr_addr] <= acc_task_tdata;
    end
endmodule
